mesi_snoop_bus: RTL and testbench

Shared snooping-bus controller and main-memory model sitting directly downstream of the per-core MESI caches. It arbitrates bus requests (BusRd, BusRdX, write-back) from NUM_CACHES caches, broadcasts each granted transaction as a snoop to the other caches, and collects their shared/flush responses. It then returns line data to the requester, either cache-to-cache from a flushing owner or from the internal memory after a fixed latency. Flushed data is always written back to memory.

---
 rtl/mesi_snoop_bus.sv | 143 ++++++++++++++
 tb/tb_mesi_snoop_bus.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mesi_snoop_bus.sv
// Snooping bus controller for NUM_CACHES MESI caches plus the backing main memory.
// Handles one transaction at a time: round-robin grant, snoop broadcast, then a fill from a flushing owner or from memory.
module mesi_snoop_bus #(
    parameter int NUM_CACHES  = 2,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CACHES-1:0]        req_valid,
    input  logic [2*NUM_CACHES-1:0]      req_type,
    input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
    input  logic [DATA_W*NUM_CACHES-1:0] req_data,
    output logic [NUM_CACHES-1:0]        req_grant,
    output logic                         snoop_rd,
    output logic                         snoop_rdx,
    output logic [ADDR_W-1:0]            snoop_addr,
    output logic [NUM_CACHES-1:0]        snoop_src,
    input  logic [NUM_CACHES-1:0]        snoop_shared,
    input  logic [NUM_CACHES-1:0]        snoop_flush,
    input  logic [DATA_W*NUM_CACHES-1:0] snoop_data,
    output logic [NUM_CACHES-1:0]        resp_valid,
    output logic [DATA_W-1:0]            resp_data,
    output logic                         resp_shared
);
    localparam int IW = $clog2(NUM_CACHES);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, SNOOP, MEM_WAIT, RESP, WRITE} state_t;

    state_t              state_q;
    logic [IW-1:0]       rr_q, src_q;
    logic                rdx_q, shared_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [CW-1:0]       cnt_q;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                gnt_found;
    logic [IW-1:0]       gnt_idx;
    logic [1:0]          gnt_type;
    logic [NUM_CACHES-1:0] src_oh, flush_m, shared_m;
    logic [IW-1:0]       fl_idx;
    logic [DATA_W-1:0]   fl_data;
    logic [IW-1:0]       rr_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;

    // First requester at or after rr_q, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CACHES; k++) begin
            if (!gnt_found && req_valid[(int'(rr_q) + k) % NUM_CACHES]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(rr_q) + k) % NUM_CACHES);
            end
        end
    end

    assign gnt_type  = req_type[gnt_idx*2 +: 2];
    assign req_grant = (state_q == IDLE && gnt_found) ? (NUM_CACHES'(1) << gnt_idx) : '0;
    assign src_oh    = NUM_CACHES'(1) << src_q;

    // The requester's own snoop answers never count.
    always_comb begin
        flush_m  = snoop_flush & ~src_oh;
        shared_m = (snoop_shared | snoop_flush) & ~src_oh;
        fl_idx   = '0;
        for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            if (flush_m[i]) fl_idx = IW'(i);
        end
        fl_data = snoop_data[fl_idx*DATA_W +: DATA_W];
    end

    assign rr_d = (int'(src_q) == NUM_CACHES - 1) ? '0 : src_q + 1'b1;

    assign mem_we    = !reset && ((state_q == SNOOP && |flush_m) || state_q == WRITE);
    assign mem_wdata = (state_q == WRITE) ? data_q : fl_data;

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            src_q    <= '0;
            rdx_q    <= 1'b0;
            shared_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_found) begin
                    src_q    <= gnt_idx;
                    addr_q   <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                    data_q   <= req_data[gnt_idx*DATA_W +: DATA_W];
                    rdx_q    <= (gnt_type == 2'b01);
                    shared_q <= 1'b0;
                    state_q  <= (gnt_type == 2'b10) ? WRITE : SNOOP;
                end
                SNOOP: begin
                    shared_q <= |shared_m;
                    if (|flush_m) begin
                        data_q  <= fl_data;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (cnt_q == CW'(MEM_LATENCY - 1)) begin
                        cnt_q   <= '0;
                        data_q  <= mem[addr_q];
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP, WRITE: begin
                    rr_q    <= rr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign snoop_rd    = (state_q == SNOOP) && !rdx_q;
    assign snoop_rdx   = (state_q == SNOOP) && rdx_q;
    assign snoop_addr  = (state_q == SNOOP) ? addr_q : '0;
    assign snoop_src   = (state_q == SNOOP) ? src_oh : '0;
    assign resp_valid  = (state_q == RESP || state_q == WRITE) ? src_oh : '0;
    assign resp_data   = (state_q == RESP || state_q == WRITE) ? data_q : '0;
    assign resp_shared = (state_q == RESP) && !rdx_q && shared_q;

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Directed bench for mesi_snoop_bus: responses are checked against a scoreboard of expected
// completions (requester, data, shared flag, completion cycle) pushed at grant time.
module tb_mesi_snoop_bus;
    localparam int N = 2, AW = 13, DW = 32, LAT = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [2*N-1:0]   req_type = '0;
    logic [AW*N-1:0]  req_addr = '0;
    logic [DW*N-1:0]  req_data = '0;
    logic [N-1:0]     req_grant;
    logic             snoop_rd, snoop_rdx;
    logic [AW-1:0]    snoop_addr;
    logic [N-1:0]     snoop_src;
    logic [N-1:0]     snoop_shared = '0;
    logic [N-1:0]     snoop_flush = '0;
    logic [DW*N-1:0]  snoop_data = '0;
    logic [N-1:0]     resp_valid;
    logic [DW-1:0]    resp_data;
    logic             resp_shared;

    mesi_snoop_bus #(.NUM_CACHES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
        .req_grant(req_grant),
        .snoop_rd(snoop_rd), .snoop_rdx(snoop_rdx), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
        .snoop_shared(snoop_shared), .snoop_flush(snoop_flush), .snoop_data(snoop_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_shared(resp_shared)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  src;
        logic [DW-1:0] data;
        logic          shared;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_valid",  64'(resp_valid),  64'(e.src));
                chk("resp_data",   64'(resp_data),   64'(e.data));
                chk("resp_shared", 64'(resp_shared), 64'(e.shared));
                chk("resp_cycle",  64'(cyc),         64'(e.cyc));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"},  64'(req_grant),   64'(0));
        chk({tag, "_snoop"},  64'({snoop_rd, snoop_rdx, snoop_addr, snoop_src}), 64'(0));
        chk({tag, "_resp"},   64'({resp_valid, resp_shared}), 64'(0));
        chk({tag, "_rdata"},  64'(resp_data),   64'(0));
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk({tag, "_drain"}, 64'(sb.size()), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One request from cache c; expected completion lat cycles after the grant.
    task automatic do_txn(input string tag, input int c, input logic [1:0] typ,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] ed, input logic es, input int lat);
        bit got = 0;
        exp_t e;
        @(posedge clk); #1;
        req_valid[c] = 1'b1;
        req_type[c*2 +: 2] = typ;
        req_addr[c*AW +: AW] = addr;
        req_data[c*DW +: DW] = wd;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_grant[c]) got = 1;
        end
        chk({tag, "_granted"}, 64'(got), 64'(1));
        if (got) begin
            chk({tag, "_grant_oh"}, 64'(req_grant), 64'(N'(1) << c));
            e.src = N'(1) << c; e.data = ed; e.shared = es; e.cyc = cyc + lat;
            sb.push_back(e);
            @(posedge clk); #1;
            req_valid[c] = 1'b0;
            if (typ != 2'b10) begin
                @(negedge clk);
                chk({tag, "_snoop_rd"},   64'(snoop_rd),   64'(typ != 2'b01));
                chk({tag, "_snoop_rdx"},  64'(snoop_rdx),  64'(typ == 2'b01));
                chk({tag, "_snoop_addr"}, 64'(snoop_addr), 64'(addr));
                chk({tag, "_snoop_src"},  64'(snoop_src),  64'(N'(1) << c));
            end
        end
        req_valid[c] = 1'b0;
        wait_drain(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        do_reset();
        @(negedge clk);
        check_idle_outputs("reset");

        // Miss everywhere: memory powers up to zero.
        do_txn("rd_miss", 0, 2'b00, 13'h0A5, 32'h0, 32'h0, 1'b0, 2 + LAT);

        // Round robin with both caches requesting continuously from reset.
        do_reset();
        @(posedge clk); #1;
        req_type = '0;
        req_addr = {13'h201, 13'h200};
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_t e;
            got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (req_grant != '0) got = 1;
            end
            chk("rr_granted", 64'(got), 64'(1));
            chk("rr_grant", 64'(req_grant), 64'(N'(1) << (t % 2)));
            e.src = N'(1) << (t % 2); e.data = '0; e.shared = 1'b0; e.cyc = cyc + 2 + LAT;
            sb.push_back(e);
            @(posedge clk); #1;
            if (t == 3) req_valid = '0;
        end
        wait_drain("rr");

        // Write-back, then a shared read sees the written value.
        do_txn("wb", 1, 2'b10, 13'h0A5, 32'h12345678, 32'h12345678, 1'b0, 1);
        snoop_shared = 2'b10;
        do_txn("rd_shared", 0, 2'b00, 13'h0A5, 32'h0, 32'h12345678, 1'b1, 2 + LAT);
        snoop_shared = '0;

        // Cache-to-cache flush on BusRdX; shared forced low, memory updated.
        snoop_flush = 2'b10; snoop_shared = 2'b10;
        snoop_data[DW +: DW] = 32'hCAFEF00D;
        do_txn("rdx_flush", 0, 2'b01, 13'h100, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        snoop_flush = '0; snoop_shared = '0;
        do_txn("rd_after_flush", 0, 2'b00, 13'h100, 32'h0, 32'hCAFEF00D, 1'b0, 2 + LAT);

        // Flush on a BusRd reports the line as shared.
        snoop_flush = 2'b01;
        snoop_data[0 +: DW] = 32'h0BADBEEF;
        do_txn("rd_flush", 1, 2'b00, 13'h100, 32'h0, 32'h0BADBEEF, 1'b1, 2);
        snoop_flush = '0;
        do_txn("rd_flush_mem", 1, 2'b00, 13'h100, 32'h0, 32'h0BADBEEF, 1'b0, 2 + LAT);

        // Type 11 behaves as BusRd.
        do_txn("type11", 1, 2'b11, 13'h0A5, 32'h0, 32'h12345678, 1'b0, 2 + LAT);

        // Requester's own flush is ignored.
        snoop_flush = 2'b01;
        snoop_data[0 +: DW] = 32'hDEADBEEF;
        do_txn("own_flush", 0, 2'b00, 13'h300, 32'h0, 32'h0, 1'b0, 2 + LAT);
        snoop_flush = '0;

        // Reset during MEM_WAIT aborts without a response.
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_type[0 +: 2] = 2'b00;
        req_addr[0 +: AW] = 13'h0A5;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_grant[0]) got = 1;
        end
        chk("abort_granted", 64'(got), 64'(1));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (8) @(negedge clk);
        chk("abort_no_pending", 64'(sb.size()), 64'(0));

        do_txn("reissue", 0, 2'b00, 13'h0A5, 32'h0, 32'h12345678, 1'b0, 2 + LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
